// File: rtl/arb_req_queue.sv
// arb_req_queue: two client FIFOs feeding a 2-way arbiter, one pop per grant.
// Ports: clk, rst (sync, active-low), push0/data0/full0, push1/data1/full1,
//   request[1:0], grant[1:0], out_valid/out_data/out_src, err.
//   Define ARB_REQ_QUEUE_CHECK_EN to build the sticky grant-protocol checker.
module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push0,
  input  logic [DATA_W-1:0] data0,
  output logic              full0,
  input  logic              push1,
  input  logic [DATA_W-1:0] data1,
  output logic              full1,
  output logic [1:0]        request,
  input  logic [1:0]        grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_t;

  state_t            state    [2];
  state_t            state_nx [2];
  logic [AW-1:0]     wp       [2];
  logic [AW-1:0]     rp       [2];
  logic [AW:0]       cnt      [2];
  logic [AW:0]       cnt_nx   [2];
  logic [DATA_W-1:0] mem      [2][DEPTH];
  logic [DATA_W-1:0] din      [2];
  logic [1:0]        push;
  logic [1:0]        full;
  logic [1:0]        push_ok;
  logic [1:0]        pop;

  assign din[0] = data0;
  assign din[1] = data1;
  assign push   = {push1, push0};
  assign full0  = full[0];
  assign full1  = full[1];

  // client 0 wins a double grant when both are requesting
  always_comb begin
    pop[0]  = (state[0] == REQ) && grant[0];
    pop[1]  = (state[1] == REQ) && grant[1] &&
              !((state[0] == REQ) && grant[0]);
    // full is the pre-edge count, so a same-cycle pop never frees a slot
    push_ok = push & ~full;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_nx[i]   = cnt[i] + (AW+1)'(push_ok[i])
                           - (AW+1)'(pop[i]);
      state_nx[i] = state[i];
      unique case (state[i])
        IDLE: if (cnt[i] != '0) state_nx[i] = REQ;
        REQ:  if (pop[i]) state_nx[i] = XFER;
        XFER: state_nx[i] = (cnt[i] != '0) ? REQ : IDLE;
        default: state_nx[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        wp[i]    <= '0;
        rp[i]    <= '0;
        cnt[i]   <= '0;
      end
      full      <= '0;
      request   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= state_nx[i];
        cnt[i]     <= cnt_nx[i];
        full[i]    <= (cnt_nx[i] == FULL_CNT);
        request[i] <= (state_nx[i] == REQ);
        if (push_ok[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])     rp[i] <= rp[i] + AW'(1);
      end
      out_valid <= |pop;
      if (pop[0]) begin
        out_data <= mem[0][rp[0]];
        out_src  <= 1'b0;
      end else if (pop[1]) begin
        out_data <= mem[1][rp[1]];
        out_src  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem[i][wp[i]] <= din[i];
    end
  end

`ifdef ARB_REQ_QUEUE_CHECK_EN
  // request mirrors the REQ state, so it is the grant-legality reference
  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else if ((grant == 2'b11) || ((grant & ~request) != 2'b00))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue: random + directed stimulus for arb_req_queue,
// checked each cycle against a queue-based reference model.
module tb_arb_req_queue;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push0 = 1'b0;
  logic [DW-1:0] data0 = '0;
  logic          full0;
  logic          push1 = 1'b0;
  logic [DW-1:0] data1 = '0;
  logic          full1;
  logic [1:0]    request;
  logic [1:0]    grant = 2'b00;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          err;

  arb_req_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push0(push0), .data0(data0), .full0(full0),
    .push1(push1), .data1(data1), .full1(full1),
    .request(request), .grant(grant),
    .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [1:0]    m_req = '0;
  logic          m_val = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_src = 1'b0;
  logic          m_err = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare every DUT output.
  task automatic step();
    logic [1:0] srv;
    logic f0, f1;
    @(posedge clk);
    if (!rst) begin
      q0.delete();
      q1.delete();
      m_req = '0; m_val = 0; m_data = '0; m_src = 0; m_err = 0;
    end else begin
      srv[0] = m_req[0] & grant[0];
      srv[1] = m_req[1] & grant[1] & ~srv[0];
`ifdef ARB_REQ_QUEUE_CHECK_EN
      if (grant == 2'b11 || (grant & ~m_req) != 2'b00) m_err = 1'b1;
`endif
      f0 = (q0.size() == DEPTH);
      f1 = (q1.size() == DEPTH);
      // a client requests whenever it holds data, except right after a pop
      m_req[0] = srv[0] ? 1'b0 : (q0.size() > 0);
      m_req[1] = srv[1] ? 1'b0 : (q1.size() > 0);
      m_val = |srv;
      if (srv[0]) begin
        m_data = q0.pop_front(); m_src = 1'b0;
      end else if (srv[1]) begin
        m_data = q1.pop_front(); m_src = 1'b1;
      end
      if (push0 && !f0) q0.push_back(data0);
      if (push1 && !f1) q1.push_back(data1);
    end
    #1;
    check("request", 32'(request), 32'(m_req));
    check("out_valid", 32'(out_valid), 32'(m_val));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_src", 32'(out_src), 32'(m_src));
    check("full0", 32'(full0), 32'(q0.size() == DEPTH));
    check("full1", 32'(full1), 32'(q1.size() == DEPTH));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle_in();
    push0 = 0; push1 = 0; grant = 2'b00;
  endtask

  initial begin
    int k;
    logic [1:0] g;
    // reset
    rst = 0; step(); step();
    check("rst_request", 32'(request), 32'h0);
    rst = 1;
    // single push on client 0
    push0 = 1; data0 = 8'hA5; step();
    push0 = 0; step();
    check("a5_request", 32'(request), 32'h1);
    grant = 2'b01; step();
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_req_drop", 32'(request), 32'h0);
    grant = 2'b00; step();
    // fill client 1, fifth push dropped
    for (int i = 0; i < 5; i++) begin
      push1 = 1; data1 = 8'(8'h10 + i); step();
      if (i == 3) check("full1_set", 32'(full1), 32'h1);
    end
    push1 = 0;
    grant = 2'b10;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) begin
        check("drain_data", 32'(out_data), 32'(8'h10 + k));
        k++;
      end
    end
    check("drain_count", k, 4);
    check("drain_req", 32'(request), 32'h0);
    // double grant with both requesting
    grant = 2'b00;
    push0 = 1; push1 = 1; data0 = 8'h31; data1 = 8'h41; step();
    data0 = 8'h32; data1 = 8'h42; step();
    idle_in(); step();
    check("both_req", 32'(request), 32'h3);
    grant = 2'b11; step();
    check("dbl_src", 32'(out_src), 32'h0);
    check("dbl_data", 32'(out_data), 32'h31);
    check("dbl_req1", 32'(request), 32'h2);
    // alternating grants drain the rest
    for (int i = 0; i < 12; i++) begin
      grant = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
    end
    // stray grant with nothing requested
    rst = 0; idle_in(); step();
    rst = 1; grant = 2'b01; step();
    check("stray_valid", 32'(out_valid), 32'h0);
    // reset while client 0 is transferring with 2 entries left
    grant = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push0 = 1; data0 = 8'(8'h50 + i); step();
    end
    push0 = 0; step();
    grant = 2'b01; step();
    rst = 0; grant = 2'b00; step();
    check("mid_rst_req", 32'(request), 32'h0);
    rst = 1;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_req", 32'(request), 32'h0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) != 0);
      push0 = ($urandom_range(0, 2) == 0);
      push1 = ($urandom_range(0, 2) == 0);
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      case ($urandom_range(0, 9))
        0: g = 2'b00;
        1: g = 2'b11;
        2: g = 2'($urandom);
        default: begin
          g = m_req;
          if (g == 2'b11) g = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        end
      endcase
      grant = g;
      step();
    end
    idle_in();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
